snn_frame_scheduler: RTL and testbench

Time-step scheduler that sequences the spiking network core. It buffers 24-bit input spike frames from the host side and issues exactly one frame to the network on each time-step tick from the clock divider. After a fixed settle window it captures the 2-bit output spikes and presents them, tagged with a step number, to a result consumer. It sits between the SPI-fed configuration/data path and the SNN core, replacing direct level-driven enabling of the core.

---
 rtl/snn_sched_pkg.sv | 17 +
 rtl/spike_frame_fifo.sv | 52 +++++
 rtl/snn_frame_scheduler.sv | 124 ++++++++++++
 tb/tb_snn_frame_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// Shared types and default parameters for the SNN time-step scheduler.
package snn_sched_pkg;

    localparam int unsigned STEP_W       = 8;
    localparam int unsigned FRAME_W_DFLT = 24;
    localparam int unsigned DEPTH_DFLT   = 4;
    localparam int unsigned OUT_W_DFLT   = 2;
    localparam int unsigned SETTLE_DFLT  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StSettle,
        StCapture
    } sched_state_e;

endpackage

// File: rtl/spike_frame_fifo.sv
// Frame buffer between the host data path and the scheduler; head is read combinationally.
module spike_frame_fifo
    import snn_sched_pkg::*;
#(
    parameter int unsigned WIDTH = FRAME_W_DFLT,
    parameter int unsigned DEPTH = DEPTH_DFLT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    // Fullness is judged before any same-cycle pop, so a full FIFO refuses a push outright.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/snn_frame_scheduler.sv
// Issues one buffered spike frame per time-step tick, waits a settle window, then captures
// the core's output spikes into a step-tagged result register.
module snn_frame_scheduler
    import snn_sched_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DFLT,
    parameter int unsigned DEPTH   = DEPTH_DFLT,
    parameter int unsigned OUT_W   = OUT_W_DFLT,
    parameter int unsigned SETTLE  = SETTLE_DFLT
) (
    input  logic                        system_clock,
    input  logic                        reset,
    input  logic                        frame_valid,
    input  logic [FRAME_W-1:0]          frame_data,
    output logic                        frame_ready,
    input  logic                        step_tick,
    input  logic                        run_en,
    input  logic                        clear_flags,
    output logic [FRAME_W-1:0]          snn_input_spikes,
    output logic                        snn_enable,
    input  logic [OUT_W-1:0]            snn_output_spikes,
    output logic                        result_valid,
    output logic [STEP_W+OUT_W-1:0]     result_data,
    input  logic                        result_ready,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic                        underrun,
    output logic                        missed_tick,
    output logic                        result_drop
);

    localparam int unsigned      CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    sched_state_e              state_q;
    logic [CNT_W-1:0]          settle_cnt_q;
    logic [STEP_W-1:0]         step_cnt_q;
    logic [FRAME_W-1:0]        spikes_q;
    logic                      enable_q;
    logic                      res_valid_q;
    logic [STEP_W+OUT_W-1:0]   res_data_q;
    logic                      underrun_q, missed_q, drop_q;

    logic                      fifo_empty, fifo_full, tick_go;
    logic [FRAME_W-1:0]        fifo_head;

    assign tick_go = step_tick && run_en && (state_q == StIdle);

    spike_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (system_clock),
        .reset     (reset),
        .push      (frame_valid),
        .push_data (frame_data),
        .pop       (tick_go),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign frame_ready      = !fifo_full;
    assign snn_input_spikes = spikes_q;
    assign snn_enable       = enable_q;
    assign result_valid     = res_valid_q;
    assign result_data      = res_data_q;
    assign underrun         = underrun_q;
    assign missed_tick      = missed_q;
    assign result_drop      = drop_q;

    always_ff @(posedge system_clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            step_cnt_q   <= '0;
            spikes_q     <= '0;
            enable_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            underrun_q   <= 1'b0;
            missed_q     <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            if (res_valid_q && result_ready) res_valid_q <= 1'b0;
            // Flag sets below come later in the block so they win over a coincident clear.
            if (clear_flags) begin
                underrun_q <= 1'b0;
                missed_q   <= 1'b0;
                drop_q     <= 1'b0;
            end
            if (step_tick && state_q != StIdle) missed_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (tick_go) begin
                        state_q  <= StIssue;
                        enable_q <= 1'b1;
                        spikes_q <= fifo_empty ? '0 : fifo_head;
                        if (fifo_empty) underrun_q <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q      <= StSettle;
                    settle_cnt_q <= '0;
                end
                StSettle: begin
                    if (settle_cnt_q == SETTLE_LAST) state_q <= StCapture;
                    else settle_cnt_q <= settle_cnt_q + 1'b1;
                end
                StCapture: begin
                    res_data_q  <= {step_cnt_q, snn_output_spikes};
                    res_valid_q <= 1'b1;
                    if (res_valid_q && !result_ready) drop_q <= 1'b1;
                    step_cnt_q  <= step_cnt_q + 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_frame_scheduler.sv
// Self-checking bench for snn_frame_scheduler against a queue-based step model.
module tb_snn_frame_scheduler;

    localparam int unsigned FRAME_W = 24;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned OUT_W   = 2;
    localparam int unsigned SETTLE  = 3;

    logic               system_clock = 1'b0;
    logic               reset        = 1'b0;
    logic               frame_valid  = 1'b0;
    logic [FRAME_W-1:0] frame_data   = '0;
    logic               frame_ready;
    logic               step_tick    = 1'b0;
    logic               run_en       = 1'b1;
    logic               clear_flags  = 1'b0;
    logic [FRAME_W-1:0] snn_input_spikes;
    logic               snn_enable;
    logic [OUT_W-1:0]   snn_output_spikes;
    logic               result_valid;
    logic [9:0]         result_data;
    logic               result_ready = 1'b0;
    logic [2:0]         fifo_level;
    logic               underrun, missed_tick, result_drop;

    snn_frame_scheduler #(
        .FRAME_W (FRAME_W),
        .DEPTH   (DEPTH),
        .OUT_W   (OUT_W),
        .SETTLE  (SETTLE)
    ) dut (
        .system_clock      (system_clock),
        .reset             (reset),
        .frame_valid       (frame_valid),
        .frame_data        (frame_data),
        .frame_ready       (frame_ready),
        .step_tick         (step_tick),
        .run_en            (run_en),
        .clear_flags       (clear_flags),
        .snn_input_spikes  (snn_input_spikes),
        .snn_enable        (snn_enable),
        .snn_output_spikes (snn_output_spikes),
        .result_valid      (result_valid),
        .result_data       (result_data),
        .result_ready      (result_ready),
        .fifo_level        (fifo_level),
        .underrun          (underrun),
        .missed_tick       (missed_tick),
        .result_drop       (result_drop)
    );

    always #5 system_clock = ~system_clock;

    function automatic logic [1:0] spk(input logic [FRAME_W-1:0] f);
        return f[1:0] ^ f[23:22];
    endfunction

    // Core model: output spikes are a fixed function of the presented frame.
    assign snn_output_spikes = spk(snn_input_spikes);

    logic [FRAME_W-1:0] mq[$];
    int                 step_m;
    int                 n_cmp = 0;
    int                 n_err = 0;

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge system_clock);
        reset = 1'b1;
        mq.delete();
        step_m = 0;
    endtask

    task automatic push_frame(input logic [FRAME_W-1:0] d);
        frame_valid = 1'b1;
        frame_data  = d;
        @(negedge system_clock);
        frame_valid = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(d);
    endtask

    task automatic pulse_accept();
        result_ready = 1'b1;
        @(negedge system_clock);
        result_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge system_clock);
        clear_flags = 1'b0;
    endtask

    // Model of one issued step: returns the frame the core should see and its result word.
    task automatic model_step(output logic [FRAME_W-1:0] f, output logic [9:0] res);
        f   = (mq.size() > 0) ? mq.pop_front() : '0;
        res = {8'(step_m), spk(f)};
        step_m++;
    endtask

    // Ticks once and observes until the result becomes visible (cycle T+3+SETTLE).
    task automatic run_step(input bit rdy_cap, output logic [FRAME_W-1:0] seen, output int en_cnt);
        step_tick = 1'b1;
        @(negedge system_clock);
        step_tick = 1'b0;
        seen   = snn_input_spikes;
        en_cnt = int'(snn_enable);
        run_en = 1'($urandom_range(0, 1));
        for (int k = 2; k <= SETTLE + 3; k++) begin
            if (rdy_cap && k == SETTLE + 3) result_ready = 1'b1;
            @(negedge system_clock);
            en_cnt += int'(snn_enable);
        end
        if (rdy_cap) result_ready = 1'b0;
        run_en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (frame_ready !== 1'b1) begin n_err++; $display("FAIL reset_frame_ready: got %b want 1", frame_ready); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (snn_input_spikes !== '0) begin n_err++; $display("FAIL reset_spikes: got %h want 0", snn_input_spikes); end
        n_cmp++; if (snn_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %b want 0", snn_enable); end
        n_cmp++; if (result_valid !== 1'b0 || result_data !== '0) begin n_err++; $display("FAIL reset_result: got %b/%h want 0/0", result_valid, result_data); end
        n_cmp++; if ({underrun, missed_tick, result_drop} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {underrun, missed_tick, result_drop}); end
    endtask

    task automatic test_basic();
        logic [FRAME_W-1:0] seen, exp_f;
        logic [9:0]         exp_r;
        int                 en;
        push_frame(24'h000001);
        push_frame(24'h000002);
        for (int s = 0; s < 2; s++) begin
            run_step(1'b0, seen, en);
            model_step(exp_f, exp_r);
            n_cmp++; if (seen !== exp_f) begin n_err++; $display("FAIL basic_frame%0d: got %h want %h", s, seen, exp_f); end
            n_cmp++; if (en !== 1) begin n_err++; $display("FAIL basic_enable%0d: got %0d pulses want 1", s, en); end
            n_cmp++; if (result_valid !== 1'b1 || result_data !== exp_r) begin n_err++; $display("FAIL basic_result%0d: got %b/%h want 1/%h", s, result_valid, result_data, exp_r); end
            pulse_accept();
            n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL basic_accept%0d: valid %b want 0", s, result_valid); end
            repeat (4) @(negedge system_clock);
        end
    endtask

    task automatic test_underrun();
        logic [FRAME_W-1:0] seen, exp_f;
        logic [9:0]         exp_r;
        int                 en;
        run_step(1'b0, seen, en);
        model_step(exp_f, exp_r);
        n_cmp++; if (seen !== '0) begin n_err++; $display("FAIL underrun_frame: got %h want 0", seen); end
        n_cmp++; if (en !== 1) begin n_err++; $display("FAIL underrun_enable: got %0d want 1", en); end
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_flag: got %b want 1", underrun); end
        n_cmp++; if (result_data !== exp_r) begin n_err++; $display("FAIL underrun_result: got %h want %h", result_data, exp_r); end
        pulse_accept();
        pulse_clear();
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_clear: got %b want 0", underrun); end
    endtask

    task automatic test_full();
        logic [FRAME_W-1:0] seen, exp_f;
        logic [9:0]         exp_r;
        int                 en;
        for (int i = 0; i < DEPTH; i++) push_frame(FRAME_W'($urandom));
        n_cmp++; if (frame_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", frame_ready); end
        n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", fifo_level); end
        // Push while full and tick on the same edge: the pop proceeds, the push is refused.
        frame_valid = 1'b1;
        frame_data  = FRAME_W'($urandom);
        step_tick   = 1'b1;
        @(negedge system_clock);
        frame_valid = 1'b0;
        step_tick   = 1'b0;
        model_step(exp_f, exp_r);
        n_cmp++; if (fifo_level !== 3'd3 || frame_ready !== 1'b1) begin n_err++; $display("FAIL full_pushpop: level %0d ready %b want 3 1", fifo_level, frame_ready); end
        n_cmp++; if (snn_input_spikes !== exp_f || snn_enable !== 1'b1) begin n_err++; $display("FAIL full_issue: got %h/%b want %h/1", snn_input_spikes, snn_enable, exp_f); end
        repeat (SETTLE + 2) @(negedge system_clock);
        n_cmp++; if (result_data !== exp_r) begin n_err++; $display("FAIL full_result: got %h want %h", result_data, exp_r); end
        pulse_accept();
        result_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            run_step(1'b0, seen, en);
            model_step(exp_f, exp_r);
            n_cmp++; if (seen !== exp_f || result_data !== exp_r) begin n_err++; $display("FAIL full_drain%0d: got %h/%h want %h/%h", i, seen, result_data, exp_f, exp_r); end
        end
        result_ready = 1'b0;
        pulse_accept();
        pulse_clear();
    endtask

    task automatic test_missed();
        logic [FRAME_W-1:0] seen, exp_f, f;
        logic [9:0]         exp_r;
        int                 en;
        f = FRAME_W'($urandom);
        push_frame(f);
        step_tick = 1'b1;
        @(negedge system_clock);
        step_tick = 1'b0;
        seen = snn_input_spikes;
        en   = int'(snn_enable);
        @(negedge system_clock);
        en += int'(snn_enable);
        step_tick = 1'b1;
        @(negedge system_clock);
        step_tick = 1'b0;
        en += int'(snn_enable);
        repeat (SETTLE) begin
            @(negedge system_clock);
            en += int'(snn_enable);
        end
        model_step(exp_f, exp_r);
        n_cmp++; if (en !== 1) begin n_err++; $display("FAIL missed_enable: got %0d want 1", en); end
        n_cmp++; if (missed_tick !== 1'b1) begin n_err++; $display("FAIL missed_flag: got %b want 1", missed_tick); end
        n_cmp++; if (seen !== exp_f || result_data !== exp_r) begin n_err++; $display("FAIL missed_result: got %h/%h want %h/%h", seen, result_data, exp_f, exp_r); end
        pulse_accept();
        pulse_clear();
        n_cmp++; if (missed_tick !== 1'b0) begin n_err++; $display("FAIL missed_clear: got %b want 0", missed_tick); end
        // A tick in IDLE with run_en low does nothing at all.
        push_frame(FRAME_W'($urandom));
        run_en    = 1'b0;
        step_tick = 1'b1;
        @(negedge system_clock);
        step_tick = 1'b0;
        en = 0;
        repeat (SETTLE + 3) begin
            en += int'(snn_enable);
            @(negedge system_clock);
        end
        run_en = 1'b1;
        n_cmp++; if (en !== 0 || missed_tick !== 1'b0) begin n_err++; $display("FAIL runen_off: pulses %0d missed %b want 0 0", en, missed_tick); end
        n_cmp++; if (fifo_level !== 3'(mq.size())) begin n_err++; $display("FAIL runen_level: got %0d want %0d", fifo_level, mq.size()); end
    endtask

    task automatic test_back_to_back();
        logic [FRAME_W-1:0] seen, exp_f;
        logic [9:0]         exp_r;
        int                 en;
        result_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 4)) push_frame(FRAME_W'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge system_clock);
            repeat ($urandom_range(1, 5)) begin
                run_step(1'b0, seen, en);
                model_step(exp_f, exp_r);
                n_cmp++;
                if (seen !== exp_f || en !== 1 || result_valid !== 1'b1 || result_data !== exp_r
                    || missed_tick !== 1'b0 || result_drop !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_step: frame %h en %0d v %b res %h mt %b dr %b want %h 1 1 %h 0 0",
                             seen, en, result_valid, result_data, missed_tick, result_drop, exp_f, exp_r);
                end
            end
        end
        result_ready = 1'b0;
        @(negedge system_clock);
        pulse_clear();
    endtask

    task automatic test_drop_wrap();
        logic [FRAME_W-1:0] seen, exp_f;
        logic [9:0]         exp_r;
        int                 en;
        do_reset();
        push_frame(FRAME_W'($urandom));
        push_frame(FRAME_W'($urandom));
        for (int s = 0; s < 2; s++) begin
            run_step(1'b0, seen, en);
            model_step(exp_f, exp_r);
        end
        n_cmp++; if (result_drop !== 1'b1) begin n_err++; $display("FAIL drop_flag: got %b want 1", result_drop); end
        n_cmp++; if (result_valid !== 1'b1 || result_data !== exp_r) begin n_err++; $display("FAIL drop_data: got %b/%h want 1/%h", result_valid, result_data, exp_r); end
        pulse_clear();
        n_cmp++; if (result_drop !== 1'b0) begin n_err++; $display("FAIL drop_clear: got %b want 0", result_drop); end
        // Acceptance coinciding with capture: new result valid, no drop.
        run_step(1'b1, seen, en);
        model_step(exp_f, exp_r);
        n_cmp++; if (result_valid !== 1'b1 || result_data !== exp_r || result_drop !== 1'b0) begin n_err++; $display("FAIL drop_sameedge: got %b/%h/%b want 1/%h/0", result_valid, result_data, result_drop, exp_r); end
        result_ready = 1'b1;
        for (int s = 0; s < 256; s++) begin
            run_step(1'b0, seen, en);
            model_step(exp_f, exp_r);
            n_cmp++; if (result_data !== exp_r) begin n_err++; $display("FAIL wrap_step%0d: got %h want %h", s, result_data, exp_r); end
        end
        result_ready = 1'b0;
        @(negedge system_clock);
    endtask

    task automatic test_reset_mid();
        int en;
        push_frame(FRAME_W'($urandom));
        step_tick = 1'b1;
        @(negedge system_clock);
        step_tick = 1'b0;
        repeat (2) @(negedge system_clock);
        reset = 1'b0;
        @(negedge system_clock);
        n_cmp++; if (snn_input_spikes !== '0 || snn_enable !== 1'b0 || fifo_level !== 3'd0) begin n_err++; $display("FAIL rstmid_core: spikes %h en %b level %0d want 0 0 0", snn_input_spikes, snn_enable, fifo_level); end
        n_cmp++; if (result_valid !== 1'b0 || result_data !== '0 || frame_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_result: v %b data %h rdy %b want 0 0 1", result_valid, result_data, frame_ready); end
        reset = 1'b1;
        mq.delete();
        step_m = 0;
        en = 0;
        repeat (SETTLE + 4) begin
            @(negedge system_clock);
            en += int'(snn_enable);
        end
        n_cmp++; if (en !== 0 || result_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after: pulses %0d valid %b want 0 0", en, result_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_full();
        test_missed();
        test_back_to_back();
        test_drop_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
